// File: rtl/seq_control_pkg.sv
// rtl/seq_control_pkg.sv - shared types for the program sequencer
package seq_control_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [2:0] {
        OP_SEQ,
        OP_JUMP,
        OP_CALL,
        OP_RET,
        OP_LOOP,
        OP_ENDL
    } op_e;

endpackage

// File: rtl/isa.sv
// rtl/isa.sv - instruction set opcode definitions
`ifndef ISA_SV
`define ISA_SV

`define JUMP 4'h8
`define CALL 4'h9
`define RET  4'hA
`define LOOP 4'hB
`define ENDL 4'hC

`endif

// File: rtl/seq_call_stack.sv
// rtl/seq_call_stack.sv - LIFO of return addresses for the sequencer
module seq_call_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] depth
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    assign full    = (ptr_q == PTR_W'(DEPTH));
    assign empty   = (ptr_q == '0);
    assign depth   = ptr_q;
    assign wr_idx  = ptr_q[IDX_W-1:0];
    assign top_idx = IDX_W'(ptr_q - 1'b1);
    assign dout    = empty ? '0 : mem_q[top_idx];

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        if (push && !full) begin
            mem_d[wr_idx] = din;
            ptr_d         = ptr_q + 1'b1;
        end else if (pop && !empty) begin
            ptr_d = ptr_q - 1'b1;
        end
    end

    // Only the pointer is reset; stale entries are unreachable once it is zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/seq_control.sv
// rtl/seq_control.sv - program sequencer with call stack and hardware loop
`include "isa.sv"

module seq_control
    import seq_control_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int INSTR_W     = 16,
    parameter int PC_STEP     = 2,
    parameter int STACK_DEPTH = 8,
    parameter int LOOP_W      = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [INSTR_W-1:0]                 instruction,
    input  logic                               instr_valid,
    input  logic                               stall,
    output logic [ADDR_W-1:0]                  program_counter,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
    output logic                               loop_active,
    output logic                               stack_overflow,
    output logic                               stack_underflow
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [LOOP_W-1:0] loop_cnt_q, loop_cnt_d;
    logic [ADDR_W-1:0] loop_start_q, loop_start_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              adv;
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] operand;
    logic [LOOP_W-1:0] count;
    logic [ADDR_W-1:0] pc_next;
    op_e               op;

    logic              stk_push;
    logic              stk_pop;
    logic [ADDR_W-1:0] stk_dout;
    logic              stk_full;
    logic              stk_empty;

    assign adv     = instr_valid & ~stall;
    assign opcode  = instruction[INSTR_W-1 -: OPC_W];
    assign operand = instruction[ADDR_W-1:0];
    assign count   = instruction[LOOP_W-1:0];
    assign pc_next = pc_q + ADDR_W'(PC_STEP);

    always_comb begin
        case (opcode)
            `JUMP:   op = OP_JUMP;
            `CALL:   op = OP_CALL;
            `RET:    op = OP_RET;
            `LOOP:   op = OP_LOOP;
            `ENDL:   op = OP_ENDL;
            default: op = OP_SEQ;
        endcase
    end

    always_comb begin
        pc_d         = pc_q;
        loop_cnt_d   = loop_cnt_q;
        loop_start_d = loop_start_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
        if (adv) begin
            pc_d = pc_next;
            case (op)
                OP_JUMP: pc_d = operand;
                OP_CALL: begin
                    if (!stk_full) begin
                        stk_push = 1'b1;
                        pc_d     = operand;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!stk_empty) begin
                        stk_pop = 1'b1;
                        pc_d    = stk_dout;
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
                OP_LOOP: begin
                    // A zero count still runs the body once.
                    loop_cnt_d   = (count == '0) ? LOOP_W'(1) : count;
                    loop_start_d = pc_next;
                end
                OP_ENDL: begin
                    if (loop_cnt_q > LOOP_W'(1)) begin
                        loop_cnt_d = loop_cnt_q - 1'b1;
                        pc_d       = loop_start_q;
                    end else begin
                        loop_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= '0;
            loop_cnt_q   <= '0;
            loop_start_q <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            loop_cnt_q   <= loop_cnt_d;
            loop_start_q <= loop_start_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    seq_call_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_next),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty),
        .depth (stack_depth)
    );

    assign program_counter = pc_q;
    assign loop_active     = (loop_cnt_q != '0);
    assign stack_overflow  = overflow_q;
    assign stack_underflow = underflow_q;

endmodule
